grant_burst_forwarder: RTL and testbench

Downstream consumer of the 4-way round-robin arbiter's one-hot grant_sigs. Latches the winning requester and forwards a fixed-length burst of BURST_LEN data beats from that requester's valid/ready channel to one shared output channel. Pulses a per-requester done flag when the burst ends, so the requester can drop or re-issue its req_sigs bit.

---
 rtl/grant_burst_forwarder_pkg.sv | 28 ++
 rtl/grant_burst_forwarder_onehot_enc4.sv | 15 +
 rtl/grant_burst_forwarder.sv | 105 ++++++++++
 tb/tb_grant_burst_forwarder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/grant_burst_forwarder_pkg.sv
// Shared definitions for arbiter grant consumers: FSM encoding, requester count
// and one-hot helpers.
package grant_burst_forwarder_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Lowest-priority match wins when called on a non-one-hot value; callers
    // are expected to qualify with is_onehot first.
    function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic is_onehot(input logic [NUM_REQ-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/grant_burst_forwarder_onehot_enc4.sv
// 4-bit one-hot to 2-bit index encoder with one-hot and multi-hot qualifiers.
module onehot_enc4
    import grant_burst_forwarder_pkg::*;
(
    input  logic [3:0] onehot,
    output logic [1:0] idx,
    output logic       one_hot,
    output logic       multi_hot
);

    assign idx       = onehot_to_idx(onehot);
    assign one_hot   = is_onehot(onehot);
    assign multi_hot = (onehot != 4'd0) && !one_hot;

endmodule

// File: rtl/grant_burst_forwarder.sv
// Latches a one-hot arbiter grant and forwards a fixed-length burst from the
// winning requester's valid/ready channel onto a single shared output channel.
module grant_burst_forwarder
    import grant_burst_forwarder_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          grant_sigs,
    input  logic [NUM_REQ*DATA_W-1:0]   in_data,
    input  logic [NUM_REQ-1:0]          in_valid,
    output logic [NUM_REQ-1:0]          in_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [1:0]                  out_src,
    output logic [NUM_REQ-1:0]          done_sigs,
    output logic                        busy,
    output logic                        grant_err
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    state_t           state;
    logic [1:0]       sel;
    logic [CNT_W-1:0] beat_cnt;

    logic [1:0] grant_idx;
    logic       grant_one_hot;
    logic       grant_multi_hot;
    logic       xfer;

    onehot_enc4 u_grant_enc (
        .onehot    (grant_sigs),
        .idx       (grant_idx),
        .one_hot   (grant_one_hot),
        .multi_hot (grant_multi_hot)
    );

    // Channel muxing is purely combinational so a beat costs no extra latency.
    always_comb begin
        in_ready  = '0;
        out_valid = 1'b0;
        out_data  = '0;
        if (state == ST_BURST) begin
            in_ready[sel] = out_ready;
            out_valid     = in_valid[sel];
            out_data      = in_data[int'(sel)*DATA_W +: DATA_W];
        end
    end

    assign xfer    = out_valid && out_ready;
    assign out_src = (state == ST_IDLE) ? 2'd0 : sel;

    // done_sigs and busy are registered alongside the state so they line up
    // exactly with DONE / BURST+DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            sel       <= 2'd0;
            beat_cnt  <= '0;
            grant_err <= 1'b0;
            done_sigs <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_one_hot) begin
                        sel      <= grant_idx;
                        beat_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= ST_BURST;
                    end else if (grant_multi_hot) begin
                        grant_err <= 1'b1;
                    end
                end
                ST_BURST: begin
                    if (xfer) begin
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt  <= '0;
                            done_sigs <= NUM_REQ'(1) << sel;
                            state     <= ST_DONE;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    done_sigs <= '0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    done_sigs <= '0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grant_burst_forwarder.sv
// Scoreboard bench for grant_burst_forwarder: stimulus pushes expected beats and
// done pulses, a negedge monitor pops and compares them as the DUT presents them.
module tb_grant_burst_forwarder;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  grant_sigs;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_src;
    logic [3:0]  done_sigs;
    logic        busy;
    logic        grant_err;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] src;
    } beat_t;

    beat_t      beat_q[$];
    logic [3:0] done_q[$];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    grant_burst_forwarder #(.DATA_W(8), .BURST_LEN(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .grant_sigs (grant_sigs),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_src    (out_src),
        .done_sigs  (done_sigs),
        .busy       (busy),
        .grant_err  (grant_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: sample mid-cycle, the handshake completes at the next posedge.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (beat_q.size() == 0) begin
                    chk("unexpected_beat", {22'd0, out_src, out_data}, 32'hFFFF_FFFF);
                end else begin
                    beat_t e;
                    e = beat_q.pop_front();
                    chk("beat_data", {24'd0, out_data}, {24'd0, e.data});
                    chk("beat_src", {30'd0, out_src}, {30'd0, e.src});
                end
            end
            if (done_sigs !== 4'd0) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", {28'd0, done_sigs}, 32'd0);
                end else begin
                    logic [3:0] d;
                    d = done_q.pop_front();
                    chk("done_sigs", {28'd0, done_sigs}, {28'd0, d});
                end
            end
        end
    end

    // mode 0: ready always high; mode 1: ready toggles; mode 2: grant moves to
    // requester 2 after the second beat and is left asserted.
    task automatic send_burst(input int req, input logic [7:0] base, input int mode);
        int         beat;
        int         cyc;
        logic [3:0] exp_rdy;
        @(posedge clk); #1;
        grant_sigs = 4'b0001 << req;
        in_valid   = 4'd0;
        for (int k = 0; k < 4; k++) begin
            beat_t b;
            b.data = base + 8'(k);
            b.src  = 2'(req);
            beat_q.push_back(b);
        end
        done_q.push_back(4'b0001 << req);
        beat = 0;
        cyc  = 0;
        while (beat < 4 && cyc < 40) begin
            @(posedge clk); #1;
            grant_sigs = (mode == 2 && beat >= 2) ? 4'b0100 : 4'b0000;
            in_data[req*8 +: 8] = base + 8'(beat);
            in_valid  = 4'b0001 << req;
            out_ready = (mode == 1) ? (cyc % 2 == 0) : 1'b1;
            #1;
            exp_rdy = out_ready ? (4'b0001 << req) : 4'b0000;
            chk("in_ready", {28'd0, in_ready}, {28'd0, exp_rdy});
            if (in_ready[req] && in_valid[req]) beat++;
            cyc++;
        end
        chk("burst_timeout", beat, 4);
        @(posedge clk); #1;
        in_valid = 4'd0;
        #1;
        chk("done_busy", {31'd0, busy}, 32'd1);
        chk("done_out_valid", {31'd0, out_valid}, 32'd0);
        chk("done_in_ready", {28'd0, in_ready}, 32'd0);
        chk("done_out_src", {30'd0, out_src}, req);
        @(posedge clk); #2;
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_done", {28'd0, done_sigs}, 32'd0);
        chk("idle_out_src", {30'd0, out_src}, 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        grant_sigs = 4'b0100;
        in_data    = 32'h3C5A_C3A5;
        in_valid   = 4'd0;
        out_ready  = 1'b0;

        // Reset held two cycles with a grant present
        repeat (2) begin
            @(posedge clk); #2;
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_done", {28'd0, done_sigs}, 32'd0);
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_in_ready", {28'd0, in_ready}, 32'd0);
            chk("rst_out_data", {24'd0, out_data}, 32'd0);
            chk("rst_out_src", {30'd0, out_src}, 32'd0);
            chk("rst_grant_err", {31'd0, grant_err}, 32'd0);
        end
        #1 rst = 1'b0;
        @(posedge clk); #2;
        chk("post_rst_busy", {31'd0, busy}, 32'd1);
        chk("post_rst_src", {30'd0, out_src}, 32'd2);
        send_burst(2, 8'h10, 0);

        // Single burst, backpressure, grant change mid-burst
        send_burst(1, 8'hA1, 0);
        send_burst(3, 8'hB0, 1);
        send_burst(0, 8'hC0, 2);
        send_burst(2, 8'hD0, 0);

        // Multi-hot grant in IDLE
        @(posedge clk); #1;
        grant_sigs = 4'b0011;
        @(posedge clk); #1;
        grant_sigs = 4'b0000;
        #1;
        chk("multi_err", {31'd0, grant_err}, 32'd1);
        chk("multi_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #2;
        chk("multi_busy2", {31'd0, busy}, 32'd0);
        send_burst(2, 8'hE0, 0);
        chk("err_sticky", {31'd0, grant_err}, 32'd1);

        // Reset in the middle of a requester 3 burst
        begin
            int beat;
            int cyc;
            @(posedge clk); #1;
            grant_sigs = 4'b1000;
            for (int k = 0; k < 2; k++) begin
                beat_t b;
                b.data = 8'h70 + 8'(k);
                b.src  = 2'd3;
                beat_q.push_back(b);
            end
            beat = 0;
            cyc  = 0;
            while (beat < 2 && cyc < 20) begin
                @(posedge clk); #1;
                grant_sigs     = 4'b0000;
                in_data[31:24] = 8'h70 + 8'(beat);
                in_valid       = 4'b1000;
                out_ready      = 1'b1;
                #1;
                if (in_ready[3]) beat++;
                cyc++;
            end
            chk("partial_timeout", beat, 2);
            @(posedge clk); #1;
            in_valid  = 4'd0;
            out_ready = 1'b0;
            rst       = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            #1;
            chk("abort_busy", {31'd0, busy}, 32'd0);
            chk("abort_done", {28'd0, done_sigs}, 32'd0);
            chk("abort_src", {30'd0, out_src}, 32'd0);
            chk("abort_err_cleared", {31'd0, grant_err}, 32'd0);
        end
        send_burst(3, 8'h80, 0);

        repeat (3) @(posedge clk);
        #2;
        chk("beats_left", beat_q.size(), 0);
        chk("dones_left", done_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d vectors, %0d miscompares", n_vec, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
